stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_pkg.sv | 37 +++
 rtl/btn_sync_edge.sv | 27 ++
 rtl/stopwatch_ctrl.sv | 141 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control slice: FSM state codes,
// BCD limit digits and the same-cycle button priority resolver.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUNNING = 2'd1,
      ST_PAUSED  = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

   typedef enum logic [2:0] {
      CMD_NONE  = 3'd0,
      CMD_CLR   = 3'd1,
      CMD_STOP  = 3'd2,
      CMD_START = 3'd3,
      CMD_LAP   = 3'd4
   } cmd_e;

   // Upper count limit 9:59.9 as BCD digits {min, sec_msd, sec_lsd, tenths}
   localparam logic [3:0]  LIM_MIN     = 4'd9;
   localparam logic [3:0]  LIM_SEC_MSD = 4'd5;
   localparam logic [3:0]  LIM_SEC_LSD = 4'd9;
   localparam logic [3:0]  LIM_TENTHS  = 4'd9;
   localparam logic [15:0] LIM_UP_BCD  = {LIM_MIN, LIM_SEC_MSD, LIM_SEC_LSD, LIM_TENTHS};

   // Only one command survives a cycle: clr > stop > start > lap
   function automatic cmd_e resolve_cmd(input logic clr, input logic stop,
                                        input logic start, input logic lap);
      if (clr)        return CMD_CLR;
      else if (stop)  return CMD_STOP;
      else if (start) return CMD_START;
      else if (lap)   return CMD_LAP;
      else            return CMD_NONE;
   endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Button conditioner: multi-flop synchronizer followed by a rising-edge
// detector, giving a single one-clk press pulse per button press.
module btn_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic press_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign press_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button conditioning, run/pause/done FSM, direction latch
// and a first-word-fall-through lap buffer with sticky overflow.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int LAP_DEPTH   = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        btn_start,
   input  logic                        btn_stop,
   input  logic                        btn_lap,
   input  logic                        btn_clr,
   input  logic                        dir_sw,
   input  logic                        tick_1ms,
   input  logic                        at_limit,
   input  logic [15:0]                 cur_time,
   input  logic                        lap_rd,
   output logic                        run,
   output logic                        dir,
   output logic                        clr_out,
   output logic                        done,
   output logic [1:0]                  state,
   output logic [15:0]                 lap_rdata,
   output logic [$clog2(LAP_DEPTH):0]  lap_count,
   output logic                        lap_empty,
   output logic                        lap_full,
   output logic                        lap_ovf
);

   localparam int AW = $clog2(LAP_DEPTH);

   logic   start_p, stop_p, lap_p, clr_p;
   cmd_e   cmd;
   state_e state_q, state_d;
   logic   dir_q, clr_out_q;
   logic   push_req, push_ok, pop_ok;

   btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_start (
      .clk(clk), .rst(rst), .btn_i(btn_start), .press_o(start_p));
   btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_stop (
      .clk(clk), .rst(rst), .btn_i(btn_stop), .press_o(stop_p));
   btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lap (
      .clk(clk), .rst(rst), .btn_i(btn_lap), .press_o(lap_p));
   btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clr (
      .clk(clk), .rst(rst), .btn_i(btn_clr), .press_o(clr_p));

   assign cmd = resolve_cmd(clr_p, stop_p, start_p, lap_p);

   always_comb begin
      state_d  = state_q;
      push_req = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd == CMD_START) state_d = ST_RUNNING;
         end
         ST_RUNNING: begin
            // Reaching the limit beats any non-clear press in the same cycle
            if (tick_1ms && at_limit) state_d = ST_DONE;
            else if (cmd == CMD_STOP) state_d = ST_PAUSED;
            else if (cmd == CMD_LAP)  push_req = 1'b1;
         end
         ST_PAUSED: begin
            if (cmd == CMD_START) state_d = ST_RUNNING;
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (cmd == CMD_CLR) begin
         state_d  = ST_IDLE;
         push_req = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         clr_out_q <= 1'b0;
         dir_q     <= 1'b1;
      end else begin
         state_q   <= state_d;
         clr_out_q <= (cmd == CMD_CLR);
         if (state_q == ST_IDLE) dir_q <= dir_sw;
      end
   end

   assign run     = (state_q == ST_RUNNING);
   assign done    = (state_q == ST_DONE);
   assign state   = state_q;
   assign dir     = dir_q;
   assign clr_out = clr_out_q;

   logic [15:0]   mem_q [LAP_DEPTH];
   logic [15:0]   hold_q;
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   cnt_q;
   logic          ovf_q;

   assign lap_empty = (cnt_q == '0);
   assign lap_full  = (cnt_q == (AW+1)'(LAP_DEPTH));
   assign pop_ok    = lap_rd & ~lap_empty;
   // A full buffer still accepts a push when a pop frees a slot that cycle
   assign push_ok   = push_req & (~lap_full | pop_ok);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
      end else if (cmd == CMD_CLR) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
         if (push_req && lap_full && !pop_ok) ovf_q <= 1'b1;
      end
   end

   // Storage carries no reset; hold_q keeps the last head so an empty read is stable
   always_ff @(posedge clk) begin
      if (push_ok)    mem_q[wr_ptr_q] <= cur_time;
      if (!lap_empty) hold_q          <= mem_q[rd_ptr_q];
   end

   assign lap_rdata = lap_empty ? hold_q : mem_q[rd_ptr_q];
   assign lap_count = cnt_q;
   assign lap_ovf   = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: a table of button/expectation steps
// plus hand-written sequences for timing, same-cycle and reset corners.
module tb_stopwatch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        btn_start, btn_stop, btn_lap, btn_clr;
   logic        dir_sw, tick_1ms, at_limit, lap_rd;
   logic [15:0] cur_time;
   logic        run, dir, clr_out, done, lap_empty, lap_full, lap_ovf;
   logic [1:0]  state;
   logic [15:0] lap_rdata;
   logic [2:0]  lap_count;

   int nchk = 0;
   int nerr = 0;

   stopwatch_ctrl #(.LAP_DEPTH(4), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst),
      .btn_start(btn_start), .btn_stop(btn_stop), .btn_lap(btn_lap), .btn_clr(btn_clr),
      .dir_sw(dir_sw), .tick_1ms(tick_1ms), .at_limit(at_limit),
      .cur_time(cur_time), .lap_rd(lap_rd),
      .run(run), .dir(dir), .clr_out(clr_out), .done(done), .state(state),
      .lap_rdata(lap_rdata), .lap_count(lap_count), .lap_empty(lap_empty),
      .lap_full(lap_full), .lap_ovf(lap_ovf));

   always #5 clk = ~clk;

   localparam logic [3:0] B_NONE  = 4'b0000;
   localparam logic [3:0] B_START = 4'b1000;
   localparam logic [3:0] B_STOP  = 4'b0100;
   localparam logic [3:0] B_LAP   = 4'b0010;
   localparam logic [3:0] B_CLR   = 4'b0001;

   typedef struct {
      logic [3:0]  btn;
      logic        dsw, tick, lim, rd;
      logic [15:0] ct;
      logic [1:0]  st;
      logic        rn, dn, dr;
      logic [2:0]  cnt;
      logic        emp, ful, ovf, ckr;
      logic [15:0] rdat;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mkv(logic [3:0] b, logic dsw, logic tk, logic lim, logic rd,
                                logic [15:0] ct, logic [1:0] st, logic rn, logic dn,
                                logic dr, logic [2:0] cnt, logic emp, logic ful,
                                logic ovf, logic ckr, logic [15:0] rdat);
      vec_t v;
      v.btn = b;  v.dsw = dsw; v.tick = tk; v.lim = lim; v.rd = rd; v.ct = ct;
      v.st = st;  v.rn = rn;   v.dn = dn;   v.dr = dr;   v.cnt = cnt;
      v.emp = emp; v.ful = ful; v.ovf = ovf; v.ckr = ckr; v.rdat = rdat;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic set_btns(input logic [3:0] b);
      {btn_start, btn_stop, btn_lap, btn_clr} = b;
   endtask

   // Called at a negedge; buttons held 4 cycles, then 4 idle cycles to settle
   task automatic step(input logic [3:0] b, input logic [15:0] ct, input logic tk,
                       input logic rd);
      set_btns(b);
      cur_time = ct;
      tick_1ms = tk;
      lap_rd   = rd;
      @(negedge clk);
      tick_1ms = 1'b0;
      lap_rd   = 1'b0;
      repeat (3) @(negedge clk);
      set_btns(B_NONE);
      repeat (4) @(negedge clk);
   endtask

   task automatic pop_once();
      lap_rd = 1'b1;
      @(negedge clk);
      lap_rd = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ntrans, nclr, nrun;
      logic [1:0] prev_st;
      vec_t v;

      rst = 1'b1;
      set_btns(B_NONE);
      dir_sw = 1'b1; tick_1ms = 1'b0; at_limit = 1'b0; lap_rd = 1'b0; cur_time = 16'h0;

      // Table: {btn, dsw, tick, lim, rd, cur_time} -> {state, run, done, dir, count, empty, full, ovf, ck_rdata, rdata}
      vq.push_back(mkv(B_START,         1,0,0,0,16'h0000, 2'd1,1,0,1, 3'd0,1,0,0, 0,16'h0000));
      vq.push_back(mkv(B_LAP,           1,0,0,0,16'h1234, 2'd1,1,0,1, 3'd1,0,0,0, 1,16'h1234));
      vq.push_back(mkv(B_LAP,           1,0,0,0,16'h2345, 2'd1,1,0,1, 3'd2,0,0,0, 1,16'h1234));
      vq.push_back(mkv(B_NONE,          1,0,0,1,16'h0000, 2'd1,1,0,1, 3'd1,0,0,0, 1,16'h2345));
      vq.push_back(mkv(B_NONE,          1,0,0,1,16'h0000, 2'd1,1,0,1, 3'd0,1,0,0, 1,16'h2345));
      vq.push_back(mkv(B_NONE,          1,0,0,1,16'h0000, 2'd1,1,0,1, 3'd0,1,0,0, 1,16'h2345));
      vq.push_back(mkv(B_LAP,           1,0,0,0,16'h1111, 2'd1,1,0,1, 3'd1,0,0,0, 1,16'h1111));
      vq.push_back(mkv(B_LAP,           1,0,0,0,16'h2222, 2'd1,1,0,1, 3'd2,0,0,0, 1,16'h1111));
      vq.push_back(mkv(B_LAP,           1,0,0,0,16'h3333, 2'd1,1,0,1, 3'd3,0,0,0, 1,16'h1111));
      vq.push_back(mkv(B_LAP,           1,0,0,0,16'h4444, 2'd1,1,0,1, 3'd4,0,1,0, 1,16'h1111));
      vq.push_back(mkv(B_LAP,           1,0,0,0,16'h5555, 2'd1,1,0,1, 3'd4,0,1,1, 1,16'h1111));
      vq.push_back(mkv(B_NONE,          0,0,0,1,16'h0000, 2'd1,1,0,1, 3'd3,0,0,1, 1,16'h2222));
      vq.push_back(mkv(B_STOP,          0,0,0,0,16'h0000, 2'd2,0,0,1, 3'd3,0,0,1, 0,16'h0000));
      vq.push_back(mkv(B_LAP,           0,0,0,0,16'h6666, 2'd2,0,0,1, 3'd3,0,0,1, 1,16'h2222));
      vq.push_back(mkv(B_START,         0,0,0,0,16'h0000, 2'd1,1,0,1, 3'd3,0,0,1, 0,16'h0000));
      vq.push_back(mkv(B_STOP,          0,0,0,0,16'h0000, 2'd2,0,0,1, 3'd3,0,0,1, 0,16'h0000));
      vq.push_back(mkv(B_START | B_CLR, 0,0,0,0,16'h0000, 2'd0,0,0,0, 3'd0,1,0,0, 0,16'h0000));
      vq.push_back(mkv(B_START,         0,0,0,0,16'h0000, 2'd1,1,0,0, 3'd0,1,0,0, 0,16'h0000));
      vq.push_back(mkv(B_NONE,          0,1,1,0,16'h0000, 2'd3,0,1,0, 3'd0,1,0,0, 0,16'h0000));
      vq.push_back(mkv(B_START,         0,0,1,0,16'h0000, 2'd3,0,1,0, 3'd0,1,0,0, 0,16'h0000));
      vq.push_back(mkv(B_LAP,           0,0,1,0,16'h7777, 2'd3,0,1,0, 3'd0,1,0,0, 0,16'h0000));
      vq.push_back(mkv(B_STOP,          0,0,1,0,16'h0000, 2'd3,0,1,0, 3'd0,1,0,0, 0,16'h0000));
      vq.push_back(mkv(B_CLR,           1,0,0,0,16'h0000, 2'd0,0,0,1, 3'd0,1,0,0, 0,16'h0000));

      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst.state",   16'(state),     16'd0);
      chk("rst.run",     16'(run),       16'd0);
      chk("rst.done",    16'(done),      16'd0);
      chk("rst.clr_out", 16'(clr_out),   16'd0);
      chk("rst.dir",     16'(dir),       16'd1);
      chk("rst.count",   16'(lap_count), 16'd0);
      chk("rst.empty",   16'(lap_empty), 16'd1);
      chk("rst.full",    16'(lap_full),  16'd0);
      chk("rst.ovf",     16'(lap_ovf),   16'd0);

      // Start held 50 cycles: run appears on the 3rd edge, one transition only
      @(negedge clk);
      set_btns(B_START);
      prev_st = state;
      ntrans  = 0;
      for (int c = 1; c <= 50; c++) begin
         @(negedge clk);
         if (state !== prev_st) ntrans++;
         prev_st = state;
         if (c == 2) begin
            chk("start_lat.state_e2", 16'(state), 16'd0);
            chk("start_lat.run_e2",   16'(run),   16'd0);
         end
         if (c == 3) begin
            chk("start_lat.state_e3", 16'(state), 16'd1);
            chk("start_lat.run_e3",   16'(run),   16'd1);
         end
      end
      set_btns(B_NONE);
      chk("start_held.transitions", 16'(ntrans), 16'd1);
      chk("start_held.state",       16'(state),  16'd1);
      repeat (4) @(negedge clk);
      step(B_CLR, 16'h0, 1'b0, 1'b0);
      chk("clr_back.state", 16'(state), 16'd0);

      foreach (vq[i]) begin
         v = vq[i];
         dir_sw   = v.dsw;
         at_limit = v.lim;
         step(v.btn, v.ct, v.tick, v.rd);
         chk($sformatf("v%0d.state", i), 16'(state),     16'(v.st));
         chk($sformatf("v%0d.run", i),   16'(run),       16'(v.rn));
         chk($sformatf("v%0d.done", i),  16'(done),      16'(v.dn));
         chk($sformatf("v%0d.dir", i),   16'(dir),       16'(v.dr));
         chk($sformatf("v%0d.count", i), 16'(lap_count), 16'(v.cnt));
         chk($sformatf("v%0d.empty", i), 16'(lap_empty), 16'(v.emp));
         chk($sformatf("v%0d.full", i),  16'(lap_full),  16'(v.ful));
         chk($sformatf("v%0d.ovf", i),   16'(lap_ovf),   16'(v.ovf));
         if (v.ckr) chk($sformatf("v%0d.rdata", i), lap_rdata, v.rdat);
      end
      at_limit = 1'b0;

      // Direction tracks dir_sw one cycle later while idle
      dir_sw = 1'b0;
      @(negedge clk);
      chk("idle_dir.follow0", 16'(dir), 16'd0);
      dir_sw = 1'b1;
      @(negedge clk);
      chk("idle_dir.follow1", 16'(dir), 16'd1);

      // start+clr in PAUSED: single clr_out pulse, run never rises
      step(B_START, 16'h0, 1'b0, 1'b0);
      step(B_STOP,  16'h0, 1'b0, 1'b0);
      chk("pause_setup.state", 16'(state), 16'd2);
      set_btns(B_START | B_CLR);
      nclr = 0;
      nrun = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (clr_out) nclr++;
         if (run) nrun++;
         if (c == 5) set_btns(B_NONE);
      end
      chk("startclr.clr_out_cycles", 16'(nclr),  16'd1);
      chk("startclr.run_cycles",     16'(nrun),  16'd0);
      chk("startclr.state",          16'(state), 16'd0);

      // Full buffer: push and pop in the same cycle both happen
      step(B_START, 16'h0, 1'b0, 1'b0);
      step(B_LAP, 16'hA001, 1'b0, 1'b0);
      step(B_LAP, 16'hA002, 1'b0, 1'b0);
      step(B_LAP, 16'hA003, 1'b0, 1'b0);
      step(B_LAP, 16'hA004, 1'b0, 1'b0);
      chk("fill.full", 16'(lap_full), 16'd1);
      cur_time = 16'hA005;
      set_btns(B_LAP);
      @(negedge clk);
      @(negedge clk);
      lap_rd = 1'b1;
      @(negedge clk);
      lap_rd = 1'b0;
      repeat (3) @(negedge clk);
      set_btns(B_NONE);
      repeat (2) @(negedge clk);
      chk("pushpop.count", 16'(lap_count), 16'd4);
      chk("pushpop.full",  16'(lap_full),  16'd1);
      chk("pushpop.ovf",   16'(lap_ovf),   16'd0);
      chk("drain.rd0", lap_rdata, 16'hA002);
      pop_once();
      chk("drain.rd1", lap_rdata, 16'hA003);
      pop_once();
      chk("drain.rd2", lap_rdata, 16'hA004);
      pop_once();
      chk("drain.rd3", lap_rdata, 16'hA005);
      pop_once();
      chk("drain.empty", 16'(lap_empty), 16'd1);

      // Reset mid-run takes effect before the next clock edge
      chk("prerst.run", 16'(run), 16'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst.run",     16'(run),     16'd0);
      chk("async_rst.state",   16'(state),   16'd0);
      chk("async_rst.clr_out", 16'(clr_out), 16'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst.clr_out", 16'(clr_out), 16'd0);
      chk("post_rst.dir",     16'(dir),     16'd1);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
